// File: rtl/rgb_ctrl_pkg.sv
// Shared definitions for the RGB LED sequencer: FSM state encoding and
// default timing for the 12 MHz board clock.
package rgb_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

  localparam int DEF_PWM_BITS      = 8;
  localparam int DEF_PRESCALE      = 47;    // 12 MHz / 48 = 250 kHz PWM tick
  localparam int DEF_WARMUP_CYCLES = 1200;  // 100 us at 12 MHz
  localparam int NUM_CH            = 3;

  // RGBLEDEN stays up through DRAIN so the PWM pins reach 0 before the driver is disabled
  function automatic logic led_enabled(input state_t s);
    return (s == ST_RUN) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/rgb_pwm_timebase.sv
// Prescaler plus PWM period counter; both free-run only while run=1 and
// are held at zero otherwise so every RUN entry starts a fresh period.
module rgb_pwm_timebase #(
  parameter int PWM_BITS = 8,
  parameter int PRESCALE = 47
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                run,
  output logic [PWM_BITS-1:0] pwm_cnt,
  output logic                tick,
  output logic                boundary
);

  localparam logic [15:0] PRESC_MAX = 16'(PRESCALE);

  logic [15:0]         presc_reg;
  logic [PWM_BITS-1:0] cnt_reg;

  assign tick     = run && (presc_reg == PRESC_MAX);
  assign boundary = tick && (&cnt_reg);
  assign pwm_cnt  = cnt_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      presc_reg <= '0;
      cnt_reg   <= '0;
    end else if (!run) begin
      presc_reg <= '0;
      cnt_reg   <= '0;
    end else if (tick) begin
      presc_reg <= '0;
      cnt_reg   <= cnt_reg + 1'b1;
    end else begin
      presc_reg <= presc_reg + 16'd1;
    end
  end

endmodule

// File: rtl/rgb_led_sequencer.sv
// Power sequencing and PWM generation for the RGB1P8V hard LED driver:
// CURREN warm-up before RGBLEDEN, one-cycle drain on shutdown, boundary-aligned duty updates.
module rgb_led_sequencer
  import rgb_ctrl_pkg::*;
#(
  parameter int PWM_BITS      = DEF_PWM_BITS,
  parameter int PRESCALE      = DEF_PRESCALE,
  parameter int WARMUP_CYCLES = DEF_WARMUP_CYCLES
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                en,
  input  logic                duty_wr,
  input  logic [PWM_BITS-1:0] duty0,
  input  logic [PWM_BITS-1:0] duty1,
  input  logic [PWM_BITS-1:0] duty2,
  output logic                ready,
  output logic                upd_pend,
  output logic                curren,
  output logic                rgbleden,
  output logic                rgb0pwm,
  output logic                rgb1pwm,
  output logic                rgb2pwm
);

  localparam int              WW        = $clog2(WARMUP_CYCLES + 1);
  localparam logic [WW-1:0]   WARM_LAST = WW'(WARMUP_CYCLES - 1);

  state_t              state_reg;
  logic [WW-1:0]       warm_cnt_reg;
  logic                ready_reg;
  logic                curren_reg;
  logic                rgbleden_reg;
  logic                upd_pend_reg;
  logic                pwm_reg [NUM_CH];
  logic [PWM_BITS-1:0] duty_in [NUM_CH];
  logic [PWM_BITS-1:0] duty_pend_reg [NUM_CH];
  logic [PWM_BITS-1:0] duty_act_reg [NUM_CH];

  logic [PWM_BITS-1:0] pwm_cnt;
  logic                tick_unused;
  logic                boundary;
  logic                run_entry;
  logic                apply;

  assign duty_in[0] = duty0;
  assign duty_in[1] = duty1;
  assign duty_in[2] = duty2;

  rgb_pwm_timebase #(
    .PWM_BITS (PWM_BITS),
    .PRESCALE (PRESCALE)
  ) u_timebase (
    .clk      (clk),
    .resetn   (resetn),
    .run      (state_reg == ST_RUN),
    .pwm_cnt  (pwm_cnt),
    .tick     (tick_unused),
    .boundary (boundary)
  );

  // Pending duties become active on RUN entry and at every period boundary
  assign run_entry = (state_reg == ST_WARMUP) && en && (warm_cnt_reg == WARM_LAST);
  assign apply     = run_entry || ((state_reg == ST_RUN) && boundary);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg    <= ST_OFF;
      warm_cnt_reg <= '0;
      ready_reg    <= 1'b0;
      curren_reg   <= 1'b0;
      rgbleden_reg <= 1'b0;
    end else begin
      ready_reg    <= (state_reg == ST_RUN);
      curren_reg   <= (state_reg != ST_OFF);
      rgbleden_reg <= led_enabled(state_reg);
      case (state_reg)
        ST_OFF: begin
          warm_cnt_reg <= '0;
          if (en) state_reg <= ST_WARMUP;
        end
        ST_WARMUP: begin
          if (!en) begin
            state_reg    <= ST_OFF;
            warm_cnt_reg <= '0;
          end else if (warm_cnt_reg == WARM_LAST) begin
            state_reg    <= ST_RUN;
            warm_cnt_reg <= '0;
          end else begin
            warm_cnt_reg <= warm_cnt_reg + 1'b1;
          end
        end
        ST_RUN: begin
          if (!en) state_reg <= ST_DRAIN;
        end
        default: state_reg <= ST_OFF;
      endcase
    end
  end

  // A write coinciding with apply lands in pending and keeps upd_pend set
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      upd_pend_reg <= 1'b0;
    end else if (duty_wr) begin
      upd_pend_reg <= 1'b1;
    end else if (apply) begin
      upd_pend_reg <= 1'b0;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          duty_pend_reg[gi] <= '0;
          duty_act_reg[gi]  <= '0;
          pwm_reg[gi]       <= 1'b0;
        end else begin
          if (duty_wr) duty_pend_reg[gi] <= duty_in[gi];
          if (apply)   duty_act_reg[gi]  <= duty_pend_reg[gi];
          pwm_reg[gi] <= (state_reg == ST_RUN) && (pwm_cnt < duty_act_reg[gi]);
        end
      end
    end
  endgenerate

  assign ready    = ready_reg;
  assign upd_pend = upd_pend_reg;
  assign curren   = curren_reg;
  assign rgbleden = rgbleden_reg;
  assign rgb0pwm  = pwm_reg[0];
  assign rgb1pwm  = pwm_reg[1];
  assign rgb2pwm  = pwm_reg[2];

endmodule

// File: tb/tb_rgb_led_sequencer.sv
// Bench for rgb_led_sequencer: two instances (PRESCALE 0 and 2) share stimulus
// and are compared every cycle against a time-based reference model.
module tb_rgb_led_sequencer;

  localparam int P_OFF = 0, P_WARM = 1, P_RUN = 2, P_DRAIN = 3;
  localparam int WARM = 8;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       en = 1'b0;
  logic       duty_wr = 1'b0;
  logic [3:0] duty0 = '0, duty1 = '0, duty2 = '0;

  logic a_ready, a_upd, a_curren, a_led, a_p0, a_p1, a_p2;
  logic b_ready, b_upd, b_curren, b_led, b_p0, b_p1, b_p2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  rgb_led_sequencer #(.PWM_BITS(4), .PRESCALE(0), .WARMUP_CYCLES(WARM)) dut_a (
    .clk(clk), .resetn(resetn), .en(en), .duty_wr(duty_wr),
    .duty0(duty0), .duty1(duty1), .duty2(duty2),
    .ready(a_ready), .upd_pend(a_upd), .curren(a_curren), .rgbleden(a_led),
    .rgb0pwm(a_p0), .rgb1pwm(a_p1), .rgb2pwm(a_p2)
  );

  rgb_led_sequencer #(.PWM_BITS(4), .PRESCALE(2), .WARMUP_CYCLES(WARM)) dut_b (
    .clk(clk), .resetn(resetn), .en(en), .duty_wr(duty_wr),
    .duty0(duty0), .duty1(duty1), .duty2(duty2),
    .ready(b_ready), .upd_pend(b_upd), .curren(b_curren), .rgbleden(b_led),
    .rgb0pwm(b_p0), .rgb1pwm(b_p1), .rgb2pwm(b_p2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Observed vector: {ready, upd_pend, curren, rgbleden, pwm2, pwm1, pwm0}
  function automatic logic [6:0] obs(input int i);
    if (i == 0) return {a_ready, a_upd, a_curren, a_led, a_p2, a_p1, a_p0};
    return {b_ready, b_upd, b_curren, b_led, b_p2, b_p1, b_p0};
  endfunction

  // Reference model: phase plus elapsed RUN time; PWM position is derived arithmetically
  int         ph [2];
  int         wn [2];
  int         rt [2];
  int         pend [2][3];
  int         act [2][3];
  bit         upd [2];
  logic [6:0] expv [2];

  function automatic int pre(input int i);
    return (i == 0) ? 0 : 2;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      ph[i] = P_OFF; wn[i] = 0; rt[i] = 0; upd[i] = 1'b0; expv[i] = '0;
      for (int k = 0; k < 3; k++) begin pend[i][k] = 0; act[i][k] = 0; end
    end
  endtask

  task automatic model_step(input int i);
    int per, pos;
    bit bnd, start;
    logic [2:0] pw;
    per = 16 * (pre(i) + 1);
    pos = (rt[i] / (pre(i) + 1)) % 16;
    for (int k = 0; k < 3; k++) pw[k] = (ph[i] == P_RUN) && (pos < act[i][k]);
    expv[i] = {ph[i] == P_RUN, 1'b0, ph[i] != P_OFF, ph[i] >= P_RUN, pw};
    bnd   = (ph[i] == P_RUN) && (rt[i] % per == per - 1);
    start = (ph[i] == P_WARM) && en && (wn[i] == WARM - 1);
    if (bnd || start) begin
      for (int k = 0; k < 3; k++) act[i][k] = pend[i][k];
      upd[i] = 1'b0;
    end
    if (duty_wr) begin
      pend[i][0] = duty0; pend[i][1] = duty1; pend[i][2] = duty2;
      upd[i] = 1'b1;
    end
    case (ph[i])
      P_OFF:  if (en) begin ph[i] = P_WARM; wn[i] = 0; end
      P_WARM: if (!en) ph[i] = P_OFF;
              else if (wn[i] == WARM - 1) begin ph[i] = P_RUN; rt[i] = 0; end
              else wn[i]++;
      P_RUN:  begin rt[i]++; if (!en) ph[i] = P_DRAIN; end
      default: ph[i] = P_OFF;
    endcase
    expv[i][5] = upd[i];
  endtask

  task automatic step();
    @(posedge clk);
    if (!resetn) model_reset();
    else begin model_step(0); model_step(1); end
    #1;
    check("a_out", obs(0), expv[0]);
    check("b_out", obs(1), expv[1]);
    check("led_without_curren", {a_led & ~a_curren, b_led & ~b_curren}, 2'b00);
    @(negedge clk);
  endtask

  task automatic count16(output int c0, output int c1, output int c2);
    c0 = 0; c1 = 0; c2 = 0;
    for (int n = 0; n < 16; n++) begin
      step();
      c0 += a_p0; c1 += a_p1; c2 += a_p2;
    end
  endtask

  int  c0, c1, c2;
  bit  found;

  initial begin
    model_reset();
    repeat (3) step();
    resetn = 1'b1;
    step();

    // Duties loaded while OFF, then power up
    duty0 = 4'd4; duty1 = 4'd0; duty2 = 4'd15; duty_wr = 1'b1;
    $display("wr duty 4/0/15 while off");
    step();
    duty_wr = 1'b0;
    en = 1'b1;
    $display("en=1");
    step();
    repeat (10) step();
    count16(c0, c1, c2);
    check("a_high_duty4", c0, 4);
    check("a_high_duty0", c1, 0);
    check("a_high_duty15", c2, 15);

    // Mid-period update on RGB0
    repeat (5) step();
    duty0 = 4'd12; duty_wr = 1'b1;
    $display("wr duty0=12 mid-period");
    step();
    duty_wr = 1'b0;
    check("a_upd_set", a_upd, 1);
    repeat (40) step();
    count16(c0, c1, c2);
    check("a_high_duty12", c0, 12);

    // Write exactly on a PRESCALE=2 period boundary
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      if (ph[1] == P_RUN && (rt[1] % 48) == 47) begin
        found = 1'b1;
        duty0 = 4'($urandom); duty1 = 4'($urandom); duty2 = 4'($urandom); duty_wr = 1'b1;
        $display("wr duty %0d/%0d/%0d on b boundary", duty0, duty1, duty2);
        step();
        duty_wr = 1'b0;
        check("b_upd_coinc", b_upd, 1);
      end else begin
        step();
      end
    end
    check("b_boundary_found", found, 1);
    repeat (60) step();

    // Shutdown from RUN, then abort a warm-up at cycle 4 and restart
    en = 1'b0;
    $display("en=0 in run");
    repeat (5) step();
    en = 1'b1;
    repeat (5) step();
    en = 1'b0;
    $display("en=0 during warmup");
    repeat (3) step();
    en = 1'b1;
    $display("re-enable");
    repeat (14) step();

    // Random traffic
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 99) < 3) en = ~en;
      duty_wr = ($urandom_range(0, 15) == 0);
      duty0 = 4'($urandom); duty1 = 4'($urandom); duty2 = 4'($urandom);
      if (duty_wr) $display("rand wr duty %0d/%0d/%0d en=%0d", duty0, duty1, duty2, en);
      step();
    end
    duty_wr = 1'b0;

    // Asynchronous reset while running
    en = 1'b1;
    repeat (30) step();
    check("a_ready_pre_reset", a_ready, 1);
    #2 resetn = 1'b0;
    #1;
    $display("async reset mid-run");
    check("a_async_reset", obs(0), 7'd0);
    check("b_async_reset", obs(1), 7'd0);
    model_reset();
    repeat (2) step();
    resetn = 1'b1;
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
